// File: rtl/iob_ram_bist_pkg.sv
// Shared types and pattern generation for the RAM BIST initiator.
// The pattern is computed at 64 bits and truncated by callers, so DATA_W must not exceed 64.
package iob_ram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR0,
    ST_RD0,
    ST_WR1,
    ST_RD1,
    ST_FLUSH,
    ST_DONE
  } bist_state_t;

  localparam int PASS_CNT = 2;
  localparam int PAT_W    = 64;

  // Truncating the 64-bit sum to DATA_W gives (seed + addr) mod 2**DATA_W.
  function automatic logic [PAT_W-1:0] bist_pattern(
    input logic [PAT_W-1:0] seed,
    input logic [PAT_W-1:0] addr,
    input logic             inv
  );
    logic [PAT_W-1:0] p;
    p = seed + addr;
    return inv ? ~p : p;
  endfunction

endpackage

// File: rtl/iob_ram_bist_cmp.sv
// Read-check stage: captures the expected word for each issued read and compares it
// against RAM data one cycle later; the mismatch strobe is combinational on that cycle.
module iob_ram_bist_cmp
  import iob_ram_bist_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              issue_vld,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              issue_inv,
  input  logic [DATA_W-1:0] seed,
  input  logic [DATA_W-1:0] rd_dat,
  output logic              mismatch,
  output logic [ADDR_W-1:0] fail_addr
);

  logic              vld_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] exp_q;
  logic [PAT_W-1:0]  exp_full;

  assign exp_full = bist_pattern(PAT_W'(seed), PAT_W'(issue_addr), issue_inv);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      vld_q  <= 1'b0;
      addr_q <= '0;
      exp_q  <= '0;
    end else begin
      vld_q  <= issue_vld;
      addr_q <= issue_addr;
      exp_q  <= exp_full[DATA_W-1:0];
    end
  end

  assign mismatch  = vld_q && (rd_dat != exp_q);
  assign fail_addr = addr_q;

endmodule

// File: rtl/iob_ram_bist_initiator.sv
// Two-pass march BIST over one RAM port: write P, check P, write ~P, check ~P.
// All RAM-side outputs are registered, so reset clears them asynchronously.
module iob_ram_bist_initiator
  import iob_ram_bist_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                start_i,
  input  logic [DATA_W-1:0]   seed_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [ADDR_W+1:0]   err_cnt_o,
  output logic [ADDR_W-1:0]   err_addr_o,
  output logic                en_o,
  output logic [DATA_W/8-1:0] we_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [DATA_W-1:0]   d_o,
  input  logic [DATA_W-1:0]   d_i
);

  localparam int CNT_W = ADDR_W + 2;
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  bist_state_t       state;
  logic [DATA_W-1:0] seed_q;
  logic              inv_q;
  logic [ADDR_W-1:0] addr_inc;
  logic              last_addr;
  logic              mismatch;
  logic [ADDR_W-1:0] fail_addr;
  logic [CNT_W-1:0]  err_cnt_nxt;
  logic [ADDR_W-1:0] err_addr_nxt;

  function automatic logic [DATA_W-1:0] pat(
    input logic [DATA_W-1:0] s,
    input logic [ADDR_W-1:0] a,
    input logic              inv
  );
    logic [PAT_W-1:0] w;
    w = bist_pattern(PAT_W'(s), PAT_W'(a), inv);
    return w[DATA_W-1:0];
  endfunction

  assign addr_inc  = addr_o + ADDR_W'(1);
  assign last_addr = (addr_o == ADDR_LAST);

  // inv_q travels with the registered read so the last RD0 compare keeps the pass-0 polarity.
  iob_ram_bist_cmp #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_cmp (
    .clk_i     (clk_i),
    .arst_n_i  (arst_n_i),
    .issue_vld (en_o && (we_o == '0)),
    .issue_addr(addr_o),
    .issue_inv (inv_q),
    .seed      (seed_q),
    .rd_dat    (d_i),
    .mismatch  (mismatch),
    .fail_addr (fail_addr)
  );

  always_comb begin
    err_cnt_nxt  = err_cnt_o;
    err_addr_nxt = err_addr_o;
    if (mismatch) begin
      if (err_cnt_o != CNT_MAX) err_cnt_nxt = err_cnt_o + CNT_W'(1);
      if (err_cnt_o == '0)      err_addr_nxt = fail_addr;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state      <= ST_IDLE;
      seed_q     <= '0;
      inv_q      <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      pass_o     <= 1'b0;
      err_cnt_o  <= '0;
      err_addr_o <= '0;
      en_o       <= 1'b0;
      we_o       <= '0;
      addr_o     <= '0;
      d_o        <= '0;
    end else begin
      err_cnt_o  <= err_cnt_nxt;
      err_addr_o <= err_addr_nxt;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state      <= ST_WR0;
            seed_q     <= seed_i;
            inv_q      <= 1'b0;
            busy_o     <= 1'b1;
            done_o     <= 1'b0;
            pass_o     <= 1'b0;
            err_cnt_o  <= '0;
            err_addr_o <= '0;
            en_o       <= 1'b1;
            we_o       <= '1;
            addr_o     <= '0;
            d_o        <= pat(seed_i, '0, 1'b0);
          end
        end
        ST_WR0, ST_WR1: begin
          if (last_addr) begin
            state  <= (state == ST_WR0) ? ST_RD0 : ST_RD1;
            we_o   <= '0;
            addr_o <= '0;
            d_o    <= '0;
          end else begin
            addr_o <= addr_inc;
            d_o    <= pat(seed_q, addr_inc, inv_q);
          end
        end
        ST_RD0: begin
          if (last_addr) begin
            state  <= ST_WR1;
            inv_q  <= 1'b1;
            we_o   <= '1;
            addr_o <= '0;
            d_o    <= pat(seed_q, '0, 1'b1);
          end else begin
            addr_o <= addr_inc;
          end
        end
        ST_RD1: begin
          if (last_addr) begin
            state  <= ST_FLUSH;
            en_o   <= 1'b0;
            addr_o <= '0;
          end else begin
            addr_o <= addr_inc;
          end
        end
        ST_FLUSH: begin
          // The final RD1 compare lands on this edge, so judge on the updated count.
          state  <= ST_DONE;
          busy_o <= 1'b0;
          done_o <= 1'b1;
          pass_o <= (err_cnt_nxt == '0);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
